// File: rtl/adder8b_seq_ctrl_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer.
// Provides the controller state encoding, the byte width and the default
// operand width in bytes.
package adder8b_seq_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder8b.sv
// Shared 8-bit adder with carry in and carry out.
// Ports:
//   A, B  : 8-bit operands
//   Cin   : carry in
//   S     : 8-bit sum
//   Cout  : carry out
module adder8b (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

// File: rtl/adder8b_seq_ctrl.sv
// Multi-byte add/subtract sequencer. Feeds one byte per cycle, LSB first,
// through a single shared adder8b and chains the carry through a register.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one byte processed per cycle, NBYTES cycles
// DONE  | result valid, done pulse; start here chains the next operation
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : request pulse, accepted in IDLE or DONE
//   sub      : 0 = A+B, 1 = A-B, latched with start
//   op_a     : operand A, latched with start
//   op_b     : operand B, latched with start
//   busy     : high while in RUN
//   done     : one-cycle pulse when result becomes valid
//   result   : sum/difference, held until the next accepted start
//   cout     : final carry out (subtract: 1 = no borrow)
//   overflow : signed overflow of the full-width operation
module adder8b_seq_ctrl
  import adder8b_seq_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [8*NBYTES-1:0]      op_a,
  input  logic [8*NBYTES-1:0]      op_b,
  output logic                     busy,
  output logic                     done,
  output logic [8*NBYTES-1:0]      result,
  output logic                     cout,
  output logic                     overflow
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_e                           state_q;
  logic [IW-1:0]                    idx_q;
  logic                             carry_q;
  logic [NBYTES-1:0][BYTE_W-1:0]    a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]    b_q;      // effective B (inverted for subtract)
  logic [NBYTES-1:0][BYTE_W-1:0]    result_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             cout_q;
  logic                             ovf_q;

  logic [BYTE_W-1:0]                add_s;
  logic                             add_co;

  adder8b u_adder (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= sub ? ~op_b : op_b;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            carry_q  <= sub;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_q[idx_q] <= add_s;
          carry_q         <= add_co;
          idx_q           <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= add_co;
            // Signed overflow: operands agree in sign but the sum does not.
            ovf_q   <= (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                       (add_s[BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder8b_seq_ctrl.sv
module tb_adder8b_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [31:0] op_a, op_b;
  logic        busy, done, cout, overflow;
  logic [31:0] result;

  logic        start1, sub1;
  logic [7:0]  op_a1, op_b1;
  logic        busy1, done1, cout1, overflow1;
  logic [7:0]  result1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder8b_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  adder8b_seq_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .op_a(op_a1), .op_b(op_b1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(overflow1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the accept edge pass.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks after the accept edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic v,
                       output int lat);
    launch(a, b, s);
    wait_done(lat);
    r = result;
    c = cout;
    v = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (result !== 32'h0)   begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%0b exp=0", cout); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    total++; if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 8'h0)
      begin bad++; $display("FAIL reset_n1 got busy=%0b done=%0b res=%h exp all 0", busy1, done1, result1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain();
    int busy_ok = 1;
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
    end
    total++; if (busy_ok != 1) begin bad++; $display("FAIL chain_busy_window got=bad busy/done exp=busy 4 cycles"); end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL chain_done_timing got done=%0b busy=%0b exp done=1 busy=0", done, busy); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL chain_result got=%h exp=00000000", result); end
    total++; if (cout !== 1'b1)    begin bad++; $display("FAIL chain_cout got=%0b exp=1", cout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL chain_ovf got=%0b exp=0", overflow); end
    tick();
    total++; if (done !== 1'b0 || cout !== 1'b1 || result !== 32'h0)
      begin bad++; $display("FAIL chain_hold got done=%0b cout=%0b res=%h exp 0/1/0", done, cout, result); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic c, v; int lat;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r, c, v, lat);
    total++; if (lat != 4) begin bad++; $display("FAIL ovf_add_lat got=%0d exp=4", lat); end
    total++; if ({r, c, v} !== {32'h8000_0000, 1'b0, 1'b1})
      begin bad++; $display("FAIL ovf_add got r=%h c=%0b v=%0b exp r=80000000 c=0 v=1", r, c, v); end
    tick();
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, r, c, v, lat);
    total++; if ({r, c, v} !== {32'h7FFF_FFFF, 1'b1, 1'b1})
      begin bad++; $display("FAIL ovf_sub got r=%h c=%0b v=%0b exp r=7fffffff c=1 v=1", r, c, v); end
    tick();
  endtask

  task automatic test_borrow();
    logic [31:0] r; logic c, v; int lat;
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, r, c, v, lat);
    total++; if ({r, c, v} !== {32'hFFFF_FFFE, 1'b0, 1'b0})
      begin bad++; $display("FAIL borrow got r=%h c=%0b v=%0b exp r=fffffffe c=0 v=0", r, c, v); end
    tick();
  endtask

  task automatic test_mid_run_start();
    int lat;
    launch(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    sub   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat != 4) begin bad++; $display("FAIL midrun_lat got=%0d exp=4", lat); end
    total++; if ({result, cout, overflow} !== {32'h2345_6789, 1'b0, 1'b0})
      begin bad++; $display("FAIL midrun_result got r=%h c=%0b v=%0b exp r=23456789 c=0 v=0", result, cout, overflow); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_no_queue got busy=%0b exp=0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(32'h9000_0000, 32'h9000_0000, 1'b0);
    wait_done(lat);
    total++; if ({result, cout, overflow} !== {32'h2000_0000, 1'b1, 1'b1})
      begin bad++; $display("FAIL b2b_first got r=%h c=%0b v=%0b exp r=20000000 c=1 v=1", result, cout, overflow); end
    launch(32'h0000_0010, 32'h0000_0003, 1'b1);
    total++; if (busy !== 1'b1 || done !== 1'b0)
      begin bad++; $display("FAIL b2b_no_bubble got busy=%0b done=%0b exp busy=1 done=0", busy, done); end
    total++; if ({result, cout, overflow} !== {32'h0, 1'b0, 1'b0})
      begin bad++; $display("FAIL b2b_clear got r=%h c=%0b v=%0b exp all 0", result, cout, overflow); end
    wait_done(lat);
    total++; if (lat != 4) begin bad++; $display("FAIL b2b_lat got=%0d exp=4", lat); end
    total++; if ({result, cout, overflow} !== {32'h0000_000D, 1'b1, 1'b0})
      begin bad++; $display("FAIL b2b_second got r=%h c=%0b v=%0b exp r=0000000d c=1 v=0", result, cout, overflow); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic c, v; int lat;
    int quiet = 1;
    launch(32'h0102_0304, 32'h1020_3040, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    total++; if ({busy, done, result, cout, overflow} !== 36'h0)
      begin bad++; $display("FAIL rstmid_clear got busy=%0b done=%0b r=%h c=%0b v=%0b exp all 0", busy, done, result, cout, overflow); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    total++; if (quiet != 1) begin bad++; $display("FAIL rstmid_no_done got=activity exp=quiet"); end
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, r, c, v, lat);
    total++; if (lat != 4 || {r, c, v} !== {32'h0000_0100, 1'b0, 1'b0})
      begin bad++; $display("FAIL rstmid_fresh got lat=%0d r=%h c=%0b v=%0b exp lat=4 r=00000100 c=0 v=0", lat, r, c, v); end
    tick();
  endtask

  task automatic test_nbytes1();
    int a, b, sa, sb, sw, exp9, lat;
    logic exp_v;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 52; i++) begin
        for (int j = 0; j < 16; j++) begin
          a = i * 5;
          b = j * 17;
          op_a1  = a[7:0];
          op_b1  = b[7:0];
          sub1   = s[0];
          start1 = 1'b1;
          tick();
          start1 = 1'b0;
          lat = 0;
          while (!done1 && lat < 10) begin
            tick();
            lat++;
          end
          exp9 = (s == 0) ? (a + b) : (a + (255 - b) + 1);
          sa = (a >= 128) ? a - 256 : a;
          sb = (b >= 128) ? b - 256 : b;
          sw = (s == 0) ? sa + sb : sa - sb;
          exp_v = (sw > 127) || (sw < -128);
          total++;
          if (lat != 1 || {cout1, result1} !== exp9[8:0] || overflow1 !== exp_v) begin
            bad++;
            $display("FAIL n1_op a=%0d b=%0d sub=%0d got lat=%0d sum=%0d v=%0b exp lat=1 sum=%0d v=%0b",
                     a, b, s, lat, {cout1, result1}, overflow1, exp9[8:0], exp_v);
          end
        end
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    start1 = 1'b0; sub1 = 1'b0; op_a1 = '0; op_b1 = '0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_borrow();
    test_mid_run_start();
    test_back_to_back();
    test_reset_mid();
    test_nbytes1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder8b_seq_ctrl.md
Name: adder8b_seq_ctrl

Overview:
Multi-byte add/subtract sequencer built around a single adder8b instance. It adds or subtracts two NBYTES-wide operands one byte per cycle, least-significant byte first, and carries between bytes in a register. It sits between a requesting datapath and the shared 8-bit adder, trading latency for area. A start/busy/done handshake frames each operation.

Parameters:
NBYTES, 4, operand width in bytes (>=1); the data width is 8*NBYTES.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
sub  input  1  0 = A+B, 1 = A-B (two's complement); latched with start.
op_a  input  8*NBYTES  operand A; latched with start.
op_b  input  8*NBYTES  operand B; latched with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when the result becomes valid.
result  output  8*NBYTES  sum/difference; held until the next accepted start.
cout  output  1  final carry out (for sub: 1 = no borrow).
overflow  output  1  signed overflow of the full-width operation.

Behaviour:
- Reset: state=IDLE; busy, done, cout, overflow = 0; result = 0; byte index = 0; carry reg = 0. Reset wins over every other event, including mid-RUN. An in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- Start accept at edge T (state IDLE or DONE, start=1):
  - latch op_a and sub;
  - latch op_b as op_b when sub=0, or ~op_b when sub=1;
  - carry reg = sub; index = 0; result cleared to 0; state -> RUN.
- RUN: adder8b sees A = byte[index] of the latched A, B = byte[index] of the latched effective B, Cin = carry reg.
  - Each edge: write S into result byte[index]; carry reg = Cout; index++.
  - After the edge with index = NBYTES-1, state -> DONE.
  - RUN lasts exactly NBYTES cycles, during edges T+1 .. T+NBYTES.
- DONE is entered after edge T+NBYTES:
  - done=1 for that one cycle;
  - cout = final carry;
  - overflow = (A_msb == Beff_msb) && (S_msb != A_msb), using bit 8*NBYTES-1.
  - result, cout and overflow stay stable until the next accepted start. At that start, cout and overflow clear to 0.
- Latency: done is high in cycle T+NBYTES+1 (5 cycles for NBYTES=4).
- DONE -> IDLE when start=0. DONE -> RUN when start=1, which gives back-to-back operation with no idle bubble.
- start=1 while in RUN is ignored: no queueing and no effect on the operation in flight.
- Changes on op_a/op_b/sub after acceptance have no effect.
- busy = (state==RUN). busy and done are never high together.
- NBYTES=1: RUN lasts one cycle, and the result must equal a single adder8b evaluation.
- Arithmetic wraps modulo 2^(8*NBYTES). No saturation.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), byte width constant 8, default NBYTES.
- Sub-module: reuse the existing adder8b (ports A, B, Cin, S, Cout) unchanged as the only datapath instance. Do not duplicate adder logic in the controller.
- Index counter width is $clog2(NBYTES) with a minimum of 1.

Test Plan:
- Add carry chain: op_a=0xFFFFFFFF, op_b=0x00000001, sub=0, start at T. Required: done exactly at T+5, busy high T+1..T+4, result=0x00000000, cout=1, overflow=0.
- Signed overflow: op_a=0x7FFFFFFF + op_b=0x00000001 -> result=0x80000000, cout=0, overflow=1. Also 0x80000000 - 0x00000001 (sub=1) -> result=0x7FFFFFFF, cout=1, overflow=1.
- Borrow: 0x00000005 - 0x00000007 (sub=1) -> result=0xFFFFFFFE, cout=0, overflow=0.
- Handshake robustness:
  - Assert start with new operands at T+2 mid-RUN: ignored, first result still correct at T+5.
  - Start asserted in the DONE cycle: second op accepted, its done arrives 5 cycles later, with no IDLE cycle in between.
- Reset mid-operation: rst=1 at T+2 -> next edge busy=0, done=0, result=0, cout=0, overflow=0. No done pulse follows. A fresh start then works normally.
- Exhaustive NBYTES=1 instance: all 256x256 a/b pairs, sub=0 and sub=1. Compare {cout,result} against a+b and a+~b+1 (9-bit) and log them to output.txt as a decimal stream for diffing.
